// File: rtl/image_buffer_if.sv
// -----------------------------------------------------------------------------
// image_buffer_if
// Groups the load port (host side) and the pixel fetch port (resize engine
// side) of image_buffer.
//
// Load handshake: a pixel transfers on a rising clk edge where LD_VALID = 1 and
// LD_READY = 1 and LD_START = 0. LD_READY depends only on registered state,
// never on LD_VALID. LD_DATA is only meaningful while LD_VALID = 1.
//
// Signals:
//   LD_START   master->slave  one-cycle pulse, begin/restart an image load
//   LD_VALID   master->slave  load pixel valid
//   LD_DATA    master->slave  load pixel (raster order)
//   LD_READY   slave->master  load pixel accepted this cycle when valid
//   LD_DONE    slave->master  one-cycle pulse after the last pixel is written
//   IMG_READY  slave->master  complete image resident, reads are served
//   REN        master->slave  read enable, active low
//   ADDR       master->slave  read address {row, col}
//   R_DATA     slave->master  registered read data, one-cycle latency
//   RD_ERR     slave->master  sticky: a read arrived with no image resident
//   dbg_state  slave->master  current FSM state (0 idle, 1 load, 2 ready)
// -----------------------------------------------------------------------------
interface image_buffer_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
);
   logic              LD_START;
   logic              LD_VALID;
   logic [DATA_W-1:0] LD_DATA;
   logic              LD_READY;
   logic              LD_DONE;
   logic              IMG_READY;
   logic              REN;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] R_DATA;
   logic              RD_ERR;
   logic [1:0]        dbg_state;

   modport master (
      output LD_START, LD_VALID, LD_DATA, REN, ADDR,
      input  LD_READY, LD_DONE, IMG_READY, R_DATA, RD_ERR, dbg_state
   );

   modport slave (
      input  LD_START, LD_VALID, LD_DATA, REN, ADDR,
      output LD_READY, LD_DONE, IMG_READY, R_DATA, RD_ERR, dbg_state
   );
endinterface

// File: rtl/image_buffer.sv
// -----------------------------------------------------------------------------
// image_buffer
// Single-port 2^ADDR_W x DATA_W image store. A host loads a full image in
// raster order through the load port; once all pixels are written the block
// serves one-cycle-latency reads to the resize engine. Reads while no complete
// image is resident return 0 and set the sticky RD_ERR flag.
//
// Ports:
//   clk  rising-edge clock
//   RST  asynchronous, active-high reset
//   bus  image_buffer_if.slave (load port, read port, status, dbg_state)
// -----------------------------------------------------------------------------
module image_buffer #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic          clk,
   input  logic          RST,
   image_buffer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] wa;
   logic              ld_ready_q;
   logic              ld_done_q;
   logic              img_ready_q;
   logic              rd_err_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_q;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   logic accept;
   logic rd_req;
   logic rd_ok;
   logic rd_bad;

   // LD_START wins over a simultaneous pixel: that pixel is dropped.
   assign accept = bus.LD_VALID & ld_ready_q & ~bus.LD_START;
   assign rd_req = ~bus.REN;
   assign rd_ok  = rd_req & (state == READY);
   assign rd_bad = rd_req & (state != READY);

   // Control FSM and all status flags. Every output is a register.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         wa          <= '0;
         ld_ready_q  <= 1'b0;
         ld_done_q   <= 1'b0;
         img_ready_q <= 1'b0;
         rd_err_q    <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         ld_done_q <= 1'b0;

         // Remembers whether the held read data is real pixel data or the
         // forced zero of an erroneous read.
         if (rd_req) begin
            rd_valid_q <= rd_ok;
         end

         if (bus.LD_START) begin
            state       <= LOAD;
            wa          <= '0;
            ld_ready_q  <= 1'b1;
            img_ready_q <= 1'b0;
            // Clearing and a same-cycle erroneous read: the error survives.
            rd_err_q    <= rd_bad;
         end else begin
            if (rd_bad) begin
               rd_err_q <= 1'b1;
            end
            if (accept) begin
               wa <= wa + 1'b1;
               // Writing the top address means wa wraps: image complete.
               if (&wa) begin
                  state       <= READY;
                  ld_ready_q  <= 1'b0;
                  img_ready_q <= 1'b1;
                  ld_done_q   <= 1'b1;
               end
            end
         end
      end
   end

   // Storage array without reset so it maps onto block RAM. Writes only happen
   // in LOAD and reads only in READY, so the single port never conflicts.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wa] <= bus.LD_DATA;
      end
      if (rd_ok) begin
         rd_q <= mem[bus.ADDR];
      end
   end

   assign bus.LD_READY  = ld_ready_q;
   assign bus.LD_DONE   = ld_done_q;
   assign bus.IMG_READY = img_ready_q;
   assign bus.RD_ERR    = rd_err_q;
   // Gating by a reset flop makes R_DATA read 0 immediately on RST and after
   // an erroneous read, while the RAM output register itself stays un-reset.
   assign bus.R_DATA    = rd_valid_q ? rd_q : '0;
   assign bus.dbg_state = state;

endmodule

// File: doc/image_buffer.md
# image_buffer

Single-port 4096×8 image store on the read side of the bilinear resize engine. The host streams a 64×64 8-bit source image in through a valid/ready load port, in raster order. Once the image is complete, the block answers the resize engine's pixel fetches: active-low `REN`, 12-bit `{row[5:0], col[5:0]}` address, registered `R_DATA` with one-cycle latency. It owns image residency and load sequencing; the engine never sees a partially loaded image.

## Interface
- `ADDR_W`, default 12: address width; depth = 2^ADDR_W; 64×64 image at default.
- `DATA_W`, default 8: pixel width.

Ports:
- `clk`  in  1  rising-edge clock.
- `RST`  in  1  asynchronous, active-high reset.
- `LD_START`  in  1  one-cycle pulse that begins a new image load.
- `LD_VALID`  in  1  load pixel valid.
- `LD_DATA`  in  DATA_W  load pixel, raster order, pixel 0 first.
- `LD_READY`  out  1  block accepts a load pixel this cycle.
- `LD_DONE`  out  1  one-cycle pulse after the last pixel is written.
- `IMG_READY`  out  1  a complete image is resident and reads are served.
- `REN`  in  1  read enable, active low.
- `ADDR`  in  ADDR_W  read address, `{row, col}`.
- `R_DATA`  out  DATA_W  registered read data.
- `RD_ERR`  out  1  sticky flag: a read was issued while `IMG_READY` = 0.

Clock `clk`, single domain; reset `RST` is asynchronous and active-high.

## Operation
- Three states:
  - IDLE: no image resident.
  - LOAD: accepting pixels.
  - READY: image resident.
- Transitions:
  - IDLE → LOAD on `LD_START`.
  - LOAD → READY when the pixel at write address 2^ADDR_W−1 is accepted.
  - READY → LOAD on `LD_START`.
  - LOAD → LOAD on `LD_START`: load restarts and the write address clears to 0.
- Write address counter `wa`, ADDR_W bits:
  - Cleared on `LD_START`.
  - Increments on each accept (`LD_VALID & LD_READY`); `mem[wa] <= LD_DATA`.
  - Its wrap to 0 is the completion event.
- `LD_READY` = 1 only in LOAD. It is registered-state decoded, with no combinational path from `LD_VALID`.
- `LD_START` has priority over a simultaneous accept: the pixel presented that cycle is dropped and the counter becomes 0.
- `LD_VALID` outside LOAD is ignored; no write occurs.
- `IMG_READY` = 1 exactly in READY.
- Read path:
  - On `REN` = 0 in READY: `R_DATA <= mem[ADDR]`.
  - On `REN` = 0 in IDLE/LOAD: `R_DATA <= 0` and `RD_ERR <= 1`.
  - On `REN` = 1: `R_DATA` holds.
- `RD_ERR` clears only on `RST` or `LD_START`. If `LD_START` and an erroneous read occur in the same cycle, the flag ends at 1.
- `LD_START` in READY with simultaneous `REN` = 0: the read is served from the current image because state is still READY that cycle; no error.
- Memory contents are not reset. After `RST` the image is treated as absent until a full reload.

## Timing
- Reset values:
  - state IDLE, `wa` = 0.
  - `LD_READY` = 0, `LD_DONE` = 0, `IMG_READY` = 0.
  - `R_DATA` = 0, `RD_ERR` = 0.
- Read latency is 1 cycle. Address and `REN` are sampled at edge N; `R_DATA` is valid after edge N and holds until the next `REN` = 0 edge. The engine issues back-to-back reads on consecutive cycles, so full throughput of one read per cycle is required.
- `LD_START` sampled at edge N: state is LOAD and `LD_READY` = 1 from after edge N. The first accept occurs at edge N+1 at the earliest.
- Load throughput is one pixel per cycle; a full load is 4096 accepts.
- Last accept at edge M: after edge M, `IMG_READY` = 1 and `LD_DONE` = 1 for that one cycle, and `LD_READY` = 0. A read at edge M+1 returns valid data.
- `RST` asserted mid-load or mid-read: all outputs return to reset values immediately (asynchronously). A partial image is never reported ready.

## Test plan
- Reset, then `LD_START` and 4096 back-to-back pixels with `LD_DATA` = `i[7:0] ^ i[11:4]` → `LD_DONE` pulses once, `IMG_READY` = 1; read `ADDR` = 0x041 → `R_DATA` = 0x45 one cycle later; read 0xFFF → 0x00.
- Load with `LD_VALID` deasserted every third cycle → exactly 4096 writes; reads at 0x000, 0x03F, 0xFC0 and 0xFFF match the pattern; `IMG_READY` does not rise before the 4096th accept.
- Engine-style burst in READY: 4 consecutive `REN` = 0 cycles at 0x041, 0x042, 0x081, 0x082 → `R_DATA` = 0x45, 0x46, 0x89, 0x8A on the following 4 cycles; `RD_ERR` stays 0.
- After 100 pixels, assert `LD_START` together with `LD_VALID`, then load 4096 pixels of constant 0xA5 → `mem[0]` = 0xA5 (the colliding pixel is dropped); `LD_DONE` comes after 4096 further accepts.
- `REN` = 0 at `ADDR` 0x010 during LOAD → `R_DATA` = 0, `RD_ERR` = 1 and it persists through completion; the next `LD_START` clears it.
- `RST` pulse at pixel 2000 → `IMG_READY` and `LD_READY` = 0 immediately; a following read sets `RD_ERR`; a full reload then yields correct data.
